// File: rtl/fht_frame_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : fht_frame_sched_if
// Brief    : Stream, FHT-control and bank-RAM signals of the frame scheduler.
// Revision : 1.0
// ============================================================================
interface fht_frame_sched_if #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
);
  logic [D_BIT-1:0] iDATA;
  logic             iVALID;
  logic             oREADY;
  logic [D_BIT-1:0] oDATA;
  logic             oVALID;
  logic             oLAST;
  logic             iREADY;
  logic             oFHT_START;
  logic             iFHT_RDY;
  logic             oRAM_SEL;
  logic [1:0]       oRAM_BANK;
  logic [A_BIT-1:0] oRAM_ADDR;
  logic [D_BIT-1:0] oRAM_WDATA;
  logic             oRAM_WE;
  logic [D_BIT-1:0] iRAM_RDATA;
  logic             oFRAME_DONE;

  modport master (
    input  iDATA, iVALID, iREADY, iFHT_RDY, iRAM_RDATA,
    output oREADY, oDATA, oVALID, oLAST, oFHT_START,
           oRAM_SEL, oRAM_BANK, oRAM_ADDR, oRAM_WDATA, oRAM_WE, oFRAME_DONE
  );

  modport slave (
    output iDATA, iVALID, iREADY, iFHT_RDY, iRAM_RDATA,
    input  oREADY, oDATA, oVALID, oLAST, oFHT_START,
           oRAM_SEL, oRAM_BANK, oRAM_ADDR, oRAM_WDATA, oRAM_WE, oFRAME_DONE
  );
endinterface
`default_nettype wire

// File: rtl/fht_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : fht_frame_sched
// Brief    : Loads one N-point frame into 4 banks, runs the FHT, unloads results.
//            Define FHT_SCHED_BITREV_EN to bit-reverse the load address.
// Revision : 1.0
// ============================================================================
module fht_frame_sched #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
) (
  input  wire logic          iCLK,
  input  wire logic          iRESET,
  fht_frame_sched_if.master  bus
);
  localparam int              K_BIT    = A_BIT + 2;
  localparam logic [K_BIT-1:0] C_K_LAST = '1;
  localparam logic [K_BIT-1:0] C_K_ONE  = {{(K_BIT-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_START  = 2'd1,
    S_RUN    = 2'd2,
    S_UNLOAD = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [K_BIT-1:0] k_q, k_d;
  logic             issued_all_q, issued_all_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_last_q, rd_last_d;
  logic             out_vld_q, out_vld_d;
  logic [D_BIT-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             skid_vld_q, skid_vld_d;
  logic [D_BIT-1:0] skid_data_q, skid_data_d;
  logic             skid_last_q, skid_last_d;

  logic             w_ready;
  logic             w_accept;
  logic             w_pop;
  logic             w_issue;
  logic [1:0]       w_occ;
  logic [K_BIT-1:0] w_wr_k;
  logic [K_BIT-1:0] w_ram_k;
  logic             w_fht_start;
  logic             w_frame_done;

`ifdef FHT_SCHED_BITREV_EN
  always_comb begin
    for (int i = 0; i < K_BIT; i++) begin
      w_wr_k[i] = k_q[K_BIT-1-i];
    end
  end
`else
  assign w_wr_k = k_q;
`endif

  assign w_ready  = (state_q == S_LOAD) && iRESET;
  assign w_accept = w_ready && bus.iVALID;
  assign w_pop    = (state_q == S_UNLOAD) && out_vld_q && bus.iREADY;

  // Occupancy after this cycle's pop: output reg, skid entry and the read in flight.
  assign w_occ   = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, rd_pend_q} - {1'b0, w_pop};
  assign w_issue = (state_q == S_UNLOAD) && !issued_all_q && (w_occ < 2'd2);
  assign w_ram_k = (state_q == S_LOAD) ? w_wr_k : k_q;

  assign bus.oREADY      = w_ready;
  assign bus.oRAM_WE     = w_accept;
  assign bus.oRAM_WDATA  = bus.iDATA;
  assign bus.oRAM_BANK   = w_ram_k[1:0];
  assign bus.oRAM_ADDR   = w_ram_k[K_BIT-1:2];
  assign bus.oRAM_SEL    = !((state_q == S_START) || (state_q == S_RUN));
  assign bus.oVALID      = out_vld_q;
  assign bus.oDATA       = out_data_q;
  assign bus.oLAST       = out_last_q;
  assign bus.oFHT_START  = w_fht_start;
  assign bus.oFRAME_DONE = w_frame_done;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    issued_all_d = issued_all_q;
    rd_pend_d    = w_issue;
    rd_last_d    = w_issue && (k_q == C_K_LAST);
    out_vld_d    = out_vld_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_vld_d   = skid_vld_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    w_fht_start  = 1'b0;
    w_frame_done = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (w_accept) begin
          if (k_q == C_K_LAST) begin
            state_d = S_START;
            k_d     = '0;
          end else begin
            k_d = k_q + C_K_ONE;
          end
        end
      end
      S_START: begin
        w_fht_start = 1'b1;
        state_d     = S_RUN;
      end
      S_RUN: begin
        if (bus.iFHT_RDY) begin
          state_d      = S_UNLOAD;
          k_d          = '0;
          issued_all_d = 1'b0;
        end
      end
      default: begin
        if (w_issue) begin
          if (k_q == C_K_LAST) begin
            issued_all_d = 1'b1;
          end else begin
            k_d = k_q + C_K_ONE;
          end
        end
        // Output register refills from the skid first so ordering is kept.
        if (w_pop || !out_vld_q) begin
          if (skid_vld_q) begin
            out_vld_d   = 1'b1;
            out_data_d  = skid_data_q;
            out_last_d  = skid_last_q;
            skid_vld_d  = rd_pend_q;
            skid_data_d = bus.iRAM_RDATA;
            skid_last_d = rd_last_q;
          end else begin
            out_vld_d  = rd_pend_q;
            out_data_d = bus.iRAM_RDATA;
            out_last_d = rd_last_q;
          end
        end else if (rd_pend_q) begin
          skid_vld_d  = 1'b1;
          skid_data_d = bus.iRAM_RDATA;
          skid_last_d = rd_last_q;
        end
        if (w_pop && out_last_q) begin
          w_frame_done = 1'b1;
          state_d      = S_LOAD;
          k_d          = '0;
          issued_all_d = 1'b0;
          rd_pend_d    = 1'b0;
          out_vld_d    = 1'b0;
          skid_vld_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q      <= S_LOAD;
      k_q          <= '0;
      issued_all_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      issued_all_q <= issued_all_d;
      rd_pend_q    <= rd_pend_d;
      rd_last_q    <= rd_last_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_vld_q   <= skid_vld_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fht_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fht_frame_sched
// Brief    : Directed bench for fht_frame_sched with N=16 and a bank-RAM model.
// Revision : 1.0
// ============================================================================
module tb_fht_frame_sched;
  localparam int A_BIT = 2;
  localparam int D_BIT = 16;

  logic iCLK;
  logic iRESET;
  int   n_pass;
  int   n_total;

  fht_frame_sched_if #(.A_BIT(A_BIT), .D_BIT(D_BIT)) bus ();

  fht_frame_sched #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .bus    (bus)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Bank RAM: flat index {addr, bank}, registered read.
  logic [D_BIT-1:0] mem [0:15];
  always @(posedge iCLK) begin
    if (bus.oRAM_WE && bus.oRAM_SEL) mem[{bus.oRAM_ADDR, bus.oRAM_BANK}] <= bus.oRAM_WDATA;
    bus.iRAM_RDATA <= mem[{bus.oRAM_ADDR, bus.oRAM_BANK}];
  end

  function automatic logic [3:0] kmap(input logic [3:0] k);
`ifdef FHT_SCHED_BITREV_EN
    return {k[0], k[1], k[2], k[3]};
`else
    return k;
`endif
  endfunction

  task automatic test_reset();
    logic [10:0] act;
    iRESET = 1'b0;
    bus.iVALID = 1'b1; bus.iREADY = 1'b1; bus.iFHT_RDY = 1'b1; bus.iDATA = 16'hABCD;
    repeat (2) @(negedge iCLK);
    #1;
    act = {bus.oREADY, bus.oVALID, bus.oLAST, bus.oFHT_START, bus.oRAM_SEL, bus.oRAM_WE,
           bus.oRAM_BANK, bus.oRAM_ADDR, bus.oFRAME_DONE};
    n_total++;
    if (act !== 11'b0000_1_0_00_00_0) $display("FAIL reset_values act=%b exp=%b", act, 11'b00001000000);
    else n_pass++;
    @(negedge iCLK);
    iRESET = 1'b1; bus.iVALID = 1'b0;
    #1;
    n_total++;
    if ({bus.oREADY, bus.oRAM_WE} !== 2'b10) $display("FAIL reset_release rdy_we act=%b exp=10", {bus.oREADY, bus.oRAM_WE});
    else n_pass++;
  endtask

  task automatic test_load(input int base, input bit gaps);
    logic [3:0]  wk;
    logic [23:0] act, exp;
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        @(negedge iCLK);
        bus.iVALID = 1'b0;
        #1;
        n_total++;
        if ({bus.oREADY, bus.oRAM_WE} !== 2'b10) $display("FAIL load_gap i=%0d act=%b exp=10", i, {bus.oREADY, bus.oRAM_WE});
        else n_pass++;
      end
      @(negedge iCLK);
      bus.iVALID = 1'b1; bus.iDATA = 16'(base + i);
      #1;
      wk  = kmap(4'(i));
      act = {bus.oFHT_START, bus.oREADY, bus.oRAM_WE, bus.oRAM_SEL, bus.oRAM_BANK, bus.oRAM_ADDR, bus.oRAM_WDATA};
      exp = {4'b0111, wk[1:0], wk[3:2], 16'(base + i)};
      n_total++;
      if (act !== exp) $display("FAIL load_write i=%0d act=%h exp=%h", i, act, exp);
      else n_pass++;
    end
    @(negedge iCLK);
    #1;
    n_total++;
    if ({bus.oFHT_START, bus.oRAM_SEL, bus.oREADY, bus.oRAM_WE} !== 4'b1000)
      $display("FAIL start_pulse act=%b exp=1000", {bus.oFHT_START, bus.oRAM_SEL, bus.oREADY, bus.oRAM_WE});
    else n_pass++;
  endtask

  task automatic test_run(input int cycles);
    int bad;
    bad = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge iCLK);
      bus.iFHT_RDY = 1'b0; bus.iVALID = 1'b1; bus.iREADY = 1'b1;
      #1;
      if ({bus.oRAM_SEL, bus.oREADY, bus.oVALID, bus.oRAM_WE, bus.oFHT_START} !== 5'b0) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL run_idle bad_cycles act=%0d exp=0", bad);
    else n_pass++;
    @(negedge iCLK);
    bus.iFHT_RDY = 1'b1;
    #1;
    n_total++;
    if ({bus.oRAM_SEL, bus.oFHT_START} !== 2'b00) $display("FAIL run_rdy_cycle act=%b exp=00", {bus.oRAM_SEL, bus.oFHT_START});
    else n_pass++;
  endtask

  task automatic test_unload_stream(input int base);
    logic [18:0] act, exp;
    @(negedge iCLK);
    bus.iREADY = 1'b1; bus.iVALID = 1'b1;
    #1;
    n_total++;
    if ({bus.oRAM_SEL, bus.oVALID, bus.oREADY, bus.oRAM_WE} !== 4'b1000)
      $display("FAIL unload_entry act=%b exp=1000", {bus.oRAM_SEL, bus.oVALID, bus.oREADY, bus.oRAM_WE});
    else n_pass++;
    @(negedge iCLK);
    #1;
    n_total++;
    if (bus.oVALID !== 1'b0) $display("FAIL unload_latency act=%b exp=0", bus.oVALID);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      @(negedge iCLK);
      #1;
      act = {bus.oVALID, bus.oLAST, bus.oFRAME_DONE, bus.oDATA};
      exp = {1'b1, i == 15, i == 15, 16'(base + int'(kmap(4'(i))))};
      n_total++;
      if (act !== exp) $display("FAIL stream_out i=%0d act=%h exp=%h", i, act, exp);
      else n_pass++;
    end
    @(negedge iCLK);
    bus.iVALID = 1'b0;
    #1;
    n_total++;
    if ({bus.oVALID, bus.oREADY, bus.oRAM_SEL} !== 3'b011)
      $display("FAIL stream_back_to_load act=%b exp=011", {bus.oVALID, bus.oREADY, bus.oRAM_SEL});
    else n_pass++;
  endtask

  task automatic test_unload_random(input int base);
    int               idx, dones, cyc, wr_bad;
    logic             prev_stall, prev_last;
    logic [D_BIT-1:0] prev_data;
    logic [16:0]      act, exp;
    idx = 0; dones = 0; cyc = 0; wr_bad = 0;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    while (idx < 16 && cyc < 400) begin
      @(negedge iCLK);
      bus.iREADY = 1'($urandom_range(0, 1)); bus.iVALID = 1'b1;
      #1;
      cyc++;
      if (bus.oRAM_WE || bus.oREADY) wr_bad++;
      if (bus.oFRAME_DONE) dones++;
      if (prev_stall) begin
        n_total++;
        if ({bus.oVALID, bus.oLAST, bus.oDATA} !== {1'b1, prev_last, prev_data})
          $display("FAIL hold_stable idx=%0d act=%h exp=%h", idx, {bus.oVALID, bus.oLAST, bus.oDATA}, {1'b1, prev_last, prev_data});
        else n_pass++;
      end
      if (bus.oVALID && bus.iREADY) begin
        act = {bus.oLAST, bus.oDATA};
        exp = {idx == 15, 16'(base + int'(kmap(4'(idx))))};
        n_total++;
        if (act !== exp) $display("FAIL random_out idx=%0d act=%h exp=%h", idx, act, exp);
        else n_pass++;
        idx++;
      end
      prev_stall = bus.oVALID && !bus.iREADY;
      prev_data  = bus.oDATA;
      prev_last  = bus.oLAST;
    end
    n_total++;
    if (idx !== 16) $display("FAIL random_count act=%0d exp=16", idx);
    else n_pass++;
    n_total++;
    if (dones !== 1) $display("FAIL frame_done_count act=%0d exp=1", dones);
    else n_pass++;
    n_total++;
    if (wr_bad !== 0) $display("FAIL unload_no_write act=%0d exp=0", wr_bad);
    else n_pass++;
    @(negedge iCLK);
    bus.iVALID = 1'b0; bus.iREADY = 1'b0;
    #1;
    n_total++;
    if ({bus.oREADY, bus.oVALID, bus.oFRAME_DONE} !== 3'b100)
      $display("FAIL random_back_to_load act=%b exp=100", {bus.oREADY, bus.oVALID, bus.oFRAME_DONE});
    else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    logic [10:0] act;
    for (int i = 0; i < 7; i++) begin
      @(negedge iCLK);
      bus.iVALID = 1'b1; bus.iDATA = 16'(500 + i);
    end
    @(negedge iCLK);
    bus.iVALID = 1'b1; bus.iDATA = 16'd507;
    iRESET = 1'b0;
    #1;
    act = {bus.oREADY, bus.oVALID, bus.oLAST, bus.oFHT_START, bus.oRAM_SEL, bus.oRAM_WE,
           bus.oRAM_BANK, bus.oRAM_ADDR, bus.oFRAME_DONE};
    n_total++;
    if (act !== 11'b0000_1_0_00_00_0) $display("FAIL reset_mid_load act=%b exp=%b", act, 11'b00001000000);
    else n_pass++;
    @(negedge iCLK);
    iRESET = 1'b1; bus.iVALID = 1'b0;
  endtask

  task automatic test_reset_mid_unload();
    logic [10:0] act;
    for (int c = 0; c < 6; c++) begin
      @(negedge iCLK);
      bus.iREADY = 1'b1; bus.iVALID = 1'b0;
    end
    #1;
    n_total++;
    if (bus.oVALID !== 1'b1) $display("FAIL mid_unload_valid act=%b exp=1", bus.oVALID);
    else n_pass++;
    iRESET = 1'b0;
    #1;
    act = {bus.oREADY, bus.oVALID, bus.oLAST, bus.oFHT_START, bus.oRAM_SEL, bus.oRAM_WE,
           bus.oRAM_BANK, bus.oRAM_ADDR, bus.oFRAME_DONE};
    n_total++;
    if (act !== 11'b0000_1_0_00_00_0) $display("FAIL reset_mid_unload act=%b exp=%b", act, 11'b00001000000);
    else n_pass++;
    @(negedge iCLK);
    iRESET = 1'b1; bus.iREADY = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_total = 0;
    iRESET = 1'b0;
    bus.iVALID = 1'b0; bus.iREADY = 1'b0; bus.iFHT_RDY = 1'b1; bus.iDATA = '0;
    test_reset();
    test_load(100, 1'b0);
    test_run(50);
    test_unload_random(100);
    test_load(200, 1'b1);
    test_run(10);
    test_unload_stream(200);
    test_reset_mid_load();
    test_load(300, 1'b0);
    test_run(5);
    test_reset_mid_unload();
    test_load(400, 1'b0);
    test_run(3);
    test_unload_stream(400);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
